// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock through a registered carry,
// with a start/ready handshake in and a one-cycle done pulse out.
module seq_chunk_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic             sub,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NCH = WIDTH / CHUNK;
    localparam int unsigned CW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             accept_c;
    logic             finish_c;
    logic             last_c;

    logic [CW-1:0]    count;
    logic             carry;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] part;

    logic [CHUNK:0]   slice_c;
    logic [WIDTH-1:0] part_next_c;
    logic             msb_cin_c;

    // Operands shift right one slice per RUN cycle, so the active slice is always the low CHUNK bits.
    assign last_c      = (count == CW'(NCH - 1));
    assign slice_c     = {1'b0, a_reg[CHUNK-1:0]} + {1'b0, b_reg[CHUNK-1:0]} + (CHUNK+1)'(carry);
    assign part_next_c = (part >> CHUNK) | (WIDTH'(slice_c[CHUNK-1:0]) << (WIDTH - CHUNK));
    // Carry into the MSB recovered from the MSB sum bit and its two operand bits.
    assign msb_cin_c   = part_next_c[WIDTH-1] ^ a_reg[CHUNK-1] ^ b_reg[CHUNK-1];

    // State register; ready is registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            ready <= 1'b1;
        end else begin
            state <= state_next;
            ready <= (state_next != ST_RUN);
        end
    end

    // Next-state logic plus accept/finish strobes.
    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        finish_c   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept_c   = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_c) begin
                    finish_c   = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    accept_c   = 1'b1;
                    state_next = ST_RUN;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath: capture on accept, one slice per RUN cycle, publish results only at completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            carry <= 1'b0;
            a_reg <= '0;
            b_reg <= '0;
            part  <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= finish_c;
            if (accept_c) begin
                a_reg <= A;
                b_reg <= B ^ {WIDTH{sub}};
                carry <= sub | cin;
                count <= '0;
            end else if (state == ST_RUN) begin
                a_reg <= a_reg >> CHUNK;
                b_reg <= b_reg >> CHUNK;
                part  <= part_next_c;
                carry <= slice_c[CHUNK];
                count <= count + CW'(1);
                if (finish_c) begin
                    sum  <= part_next_c;
                    cout <= slice_c[CHUNK];
                    ovf  <= slice_c[CHUNK] ^ msb_cin_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Scoreboard bench for seq_chunk_adder: a CHUNK=4 instance and a CHUNK=16 instance.
module tb_seq_chunk_adder;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    logic        clk;
    logic        reset;

    logic        start4, cin4, sub4, ready4, done4, cout4, ovf4;
    logic [15:0] a4, b4, sum4;
    logic        start16, cin16, sub16, ready16, done16, cout16, ovf16;
    logic [15:0] a16, b16, sum16;

    res_t q4[$];
    res_t q16[$];
    int   n_checks;
    int   n_pass;

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start4), .A(a4), .B(b4), .cin(cin4), .sub(sub4),
        .ready(ready4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) u_dut16 (
        .clk(clk), .reset(reset), .start(start16), .A(a16), .B(b16), .cin(cin16), .sub(sub16),
        .ready(ready16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Reference: full-width add with signed overflow from operand/result sign bits.
    function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic c, input logic s);
        res_t        r;
        logic [15:0] bb;
        logic [16:0] full;
        bb     = s ? ~b : b;
        full   = {1'b0, a} + {1'b0, bb} + 17'(s ? 1'b1 : c);
        r.sum  = full[15:0];
        r.cout = full[16];
        r.ovf  = (a[15] == bb[15]) && (full[15] != a[15]);
        return r;
    endfunction

    // Scoreboard compare on every done pulse.
    always @(negedge clk) begin
        res_t r;
        if (done4) begin
            if (q4.size() == 0) check("done4_unexpected", 32'd1, 32'd0);
            else begin
                r = q4.pop_front();
                check("sum4", 32'(sum4), 32'(r.sum));
                check("cout4", 32'(cout4), 32'(r.cout));
                check("ovf4", 32'(ovf4), 32'(r.ovf));
            end
        end
        if (done16) begin
            if (q16.size() == 0) check("done16_unexpected", 32'd1, 32'd0);
            else begin
                r = q16.pop_front();
                check("sum16", 32'(sum16), 32'(r.sum));
                check("cout16", 32'(cout16), 32'(r.cout));
                check("ovf16", 32'(ovf16), 32'(r.ovf));
            end
        end
    end

    task automatic wait_ready4();
        int n;
        n = 0;
        while (!ready4 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready4) check("ready4_timeout", 32'(ready4), 32'd1);
    endtask

    // One CHUNK=4 op; optional start pulse mid-RUN; checks done latency.
    task automatic op4(input logic [15:0] a, input logic [15:0] b, input logic c,
                       input logic s, input bit poke);
        int lat;
        wait_ready4();
        start4 = 1'b1; a4 = a; b4 = b; cin4 = c; sub4 = s;
        q4.push_back(model(a, b, c, s));
        @(posedge clk);
        #1;
        start4 = 1'b0; a4 = 16'($urandom); b4 = 16'($urandom);
        cin4 = 1'($urandom); sub4 = 1'($urandom);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (poke && i == 2) start4 = 1'b1;
            if (poke && i == 3) start4 = 1'b0;
            if (done4) begin
                lat = i;
                break;
            end
        end
        check("latency4", 32'(lat), 32'd4);
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s);
        int lat;
        check("ready16", 32'(ready16), 32'd1);
        start16 = 1'b1; a16 = a; b16 = b; cin16 = c; sub16 = s;
        q16.push_back(model(a, b, c, s));
        @(posedge clk);
        #1;
        start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done16) begin
                lat = i;
                break;
            end
        end
        check("latency16", 32'(lat), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t1;
        int t2;
        int ndone;
        n_checks = 0; n_pass = 0;
        reset = 1'b1;
        start4 = 0; a4 = 0; b4 = 0; cin4 = 0; sub4 = 0;
        start16 = 0; a16 = 0; b16 = 0; cin16 = 0; sub16 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_sum4", 32'(sum4), 32'h0);
        check("rst_cout4", 32'(cout4), 32'd0);
        check("rst_ovf4", 32'(ovf4), 32'd0);
        check("rst_done4", 32'(done4), 32'd0);
        check("rst_ready4", 32'(ready4), 32'd1);
        check("rst_ready16", 32'(ready16), 32'd1);
        reset = 1'b0;
        @(negedge clk);

        op4(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0);
        op4(16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0);
        op4(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        op4(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0);
        op4(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0);
        op4(16'h1357, 16'h2468, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++)
            op4(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);

        // Back-to-back: start held high through RUN and DONE.
        wait_ready4();
        start4 = 1'b1; a4 = 16'h1111; b4 = 16'h2222; cin4 = 0; sub4 = 0;
        q4.push_back(model(16'h1111, 16'h2222, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        a4 = 16'h0100; b4 = 16'h0200; sub4 = 1'b1;
        q4.push_back(model(16'h0100, 16'h0200, 1'b0, 1'b1));
        t1 = -1; t2 = -1;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (t1 >= 0 && i == t1 + 1) start4 = 1'b0;
            if (done4) begin
                if (t1 < 0) t1 = i;
                else begin
                    t2 = i;
                    break;
                end
            end
        end
        check("b2b_first_latency", 32'(t1), 32'd4);
        check("b2b_spacing", 32'(t2 - t1), 32'd5);

        // Reset two cycles into RUN discards the op.
        @(negedge clk);
        start4 = 1'b1; a4 = 16'hAAAA; b4 = 16'h5555; cin4 = 1'b1; sub4 = 1'b0;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("mid_rst_sum4", 32'(sum4), 32'h0);
        check("mid_rst_cout4", 32'(cout4), 32'd0);
        check("mid_rst_ovf4", 32'(ovf4), 32'd0);
        check("mid_rst_ready4", 32'(ready4), 32'd1);
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done4) ndone++;
        end
        check("mid_rst_no_done", 32'(ndone), 32'd0);
        op4(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0);

        // Single-slice instance.
        op16(16'h1234, 16'h1111, 1'b0, 1'b0);
        op16(16'h8000, 16'h0001, 1'b0, 1'b1);
        op16(16'hFFFF, 16'h0001, 1'b1, 1'b0);

        repeat (4) @(negedge clk);
        check("q4_drained", 32'(q4.size()), 32'd0);
        check("q16_drained", 32'(q16.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
